// File: rtl/dpi_pkg.sv
// dpi_pkg: shared types and constants for the stream dispatcher and its flow table
package dpi_pkg;

    localparam int STREAM_ID_W = 6;
    localparam int NUM_STREAMS = 64;
    localparam int KEY_W       = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_LOAD,
        S_GAP,
        S_STREAM,
        S_EOP
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [KEY_W-1:0] key;
    } flow_entry_t;

endpackage

// File: rtl/dpi_flow_table.sv
// dpi_flow_table: 64-entry flow-key table with parallel match, lowest-free allocation,
// round-robin eviction when full, and (with DPI_FLOW_INVAL_EN) an invalidation port
module dpi_flow_table
    import dpi_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   lookup,
    input  logic [KEY_W-1:0]       key,
    output logic [STREAM_ID_W-1:0] sid,
    output logic                   is_new,
    output logic                   evict
`ifdef DPI_FLOW_INVAL_EN
    ,
    input  logic                   inval_req,
    input  logic [STREAM_ID_W-1:0] inval_id
`endif
);

    flow_entry_t            tbl [NUM_STREAMS];
    logic [STREAM_ID_W-1:0] rr_ptr;
    logic [STREAM_ID_W-1:0] hit_idx;
    logic [STREAM_ID_W-1:0] free_idx;
    logic                   hit;
    logic                   free;

    // parallel key match and lowest-invalid search; descending scan lets the lowest index win
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (tbl[i].valid && tbl[i].key == key) begin
                hit     = 1'b1;
                hit_idx = STREAM_ID_W'(i);
            end
            if (!tbl[i].valid) begin
                free     = 1'b1;
                free_idx = STREAM_ID_W'(i);
            end
        end
    end

    assign sid    = hit ? hit_idx : free ? free_idx : rr_ptr;
    assign is_new = !hit;
    assign evict  = lookup && !hit && !free;

    // valid bits and rr_ptr reset; keys are plain storage; a lookup install overrides an invalidate
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            for (int i = 0; i < NUM_STREAMS; i++) tbl[i].valid <= 1'b0;
        end else begin
`ifdef DPI_FLOW_INVAL_EN
            if (inval_req) tbl[inval_id].valid <= 1'b0;
`endif
            if (lookup && !hit) tbl[sid] <= '{valid: 1'b1, key: key};
            if (evict) rr_ptr <= rr_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/dpi_stream_dispatcher.sv
// dpi_stream_dispatcher: maps packet flow keys to stream ids and sequences load/char/eop
// onto the matcher bank; optional flow invalidation port under DPI_FLOW_INVAL_EN
module dpi_stream_dispatcher
    import dpi_pkg::*;
#(
    parameter int FLOW_KEY_W = 32,
    parameter int NUM_REGEX  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [FLOW_KEY_W-1:0]  in_flow_key,
    input  logic                   cfg_we,
    input  logic [STREAM_ID_W-1:0] cfg_addr,
    input  logic [NUM_REGEX-1:0]   cfg_wdata,
    output logic [7:0]             char_in,
    output logic                   char_in_vld,
    output logic                   load_state,
    output logic [STREAM_ID_W-1:0] stream_id,
    output logic                   new_stream_id,
    output logic                   eop,
    output logic [NUM_REGEX-1:0]   enable,
    output logic                   busy,
    output logic [15:0]            evict_cnt,
    output logic [15:0]            drop_cnt
`ifdef DPI_FLOW_INVAL_EN
    ,
    input  logic                   inval_req,
    input  logic [STREAM_ID_W-1:0] inval_id
`endif
);

    state_t                 state;
    state_t                 state_nx;
    logic [FLOW_KEY_W-1:0]  key_q;
    logic [NUM_REGEX-1:0]   en_tbl [NUM_STREAMS];
    logic [STREAM_ID_W-1:0] ft_sid;
    logic                   ft_new;
    logic                   ft_evict;
    logic                   lookup;
    logic                   idle_sop;
    logic                   idle_drop;

    assign lookup    = state == S_LOOKUP;
    assign idle_sop  = state == S_IDLE && in_valid && in_sop;
    assign idle_drop = state == S_IDLE && in_valid && !in_sop;

    dpi_flow_table u_flow_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .lookup    (lookup),
        .key       (KEY_W'(key_q)),
        .sid       (ft_sid),
        .is_new    (ft_new),
        .evict     (ft_evict)
`ifdef DPI_FLOW_INVAL_EN
        ,
        .inval_req (inval_req),
        .inval_id  (inval_id)
`endif
    );

    // state register
    always_ff @(posedge clk)
        state <= !rst_n ? S_IDLE : state_nx;

    // next state: fixed one-cycle LOOKUP/LOAD/GAP/EOP, STREAM until an accepted eop beat
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = idle_sop ? S_LOOKUP : S_IDLE;
            S_LOOKUP: state_nx = S_LOAD;
            S_LOAD:   state_nx = S_GAP;
            S_GAP:    state_nx = S_STREAM;
            S_STREAM: state_nx = (in_valid && in_eop) ? S_EOP : S_STREAM;
            S_EOP:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // strobes and pass-through; held at zero while reset is asserted
    always_comb begin
        in_ready    = rst_n && (state == S_STREAM || (state == S_IDLE && !in_sop));
        char_in_vld = rst_n && state == S_STREAM && in_valid;
        char_in     = (rst_n && state == S_STREAM) ? in_data : 8'h00;
        load_state  = rst_n && state == S_LOAD;
        eop         = rst_n && state == S_EOP;
        busy        = state != S_IDLE;
    end

    // latch the SOP key, capture the lookup result for the packet, count drops and evictions
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stream_id     <= '0;
            new_stream_id <= 1'b0;
            enable        <= '0;
            evict_cnt     <= '0;
            drop_cnt      <= '0;
        end else begin
            if (idle_sop) key_q <= in_flow_key;
            if (lookup) begin
                stream_id     <= ft_sid;
                new_stream_id <= ft_new;
                enable        <= en_tbl[ft_sid];
            end
            if (ft_evict && evict_cnt != 16'hFFFF) evict_cnt <= evict_cnt + 16'd1;
            if (idle_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // per-stream enable RAM; contents survive reset
    always_ff @(posedge clk)
        if (cfg_we) en_tbl[cfg_addr] <= cfg_wdata;

endmodule

// File: tb/tb_dpi_stream_dispatcher.sv
// tb_dpi_stream_dispatcher: randomized packets against a queue-based flow/enable model
module tb_dpi_stream_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sop, in_eop, cfg_we;
    logic [7:0]  in_data;
    logic [31:0] in_flow_key;
    logic [5:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [7:0]  char_in;
    logic        char_in_vld, load_state, new_stream_id, eop, busy;
    logic [5:0]  stream_id;
    logic [15:0] enable, evict_cnt, drop_cnt;

    always #5 clk = ~clk;

    dpi_stream_dispatcher dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_sop        (in_sop),
        .in_eop        (in_eop),
        .in_flow_key   (in_flow_key),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .char_in       (char_in),
        .char_in_vld   (char_in_vld),
        .load_state    (load_state),
        .stream_id     (stream_id),
        .new_stream_id (new_stream_id),
        .eop           (eop),
        .enable        (enable),
        .busy          (busy),
        .evict_cnt     (evict_cnt),
        .drop_cnt      (drop_cnt)
`ifdef DPI_FLOW_INVAL_EN
        ,
        .inval_req     (1'b0),
        .inval_id      (6'd0)
`endif
    );

    typedef struct { int sid; bit nw; logic [15:0] en; int ev; } ld_t;
    typedef struct { logic [7:0] d; bit last; } by_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    ld_t         ld_q[$];
    by_t         by_q[$];
    logic [7:0]  pkt[$];
    logic [31:0] m_key [64];
    bit          m_val [64];
    logic [15:0] m_en  [64];
    int          m_rr = 0, m_evict = 0, m_drop = 0;
    int          cyc_n = 0, load_cyc = 0, first_gap = -1, pkt_chars = 0;
    int          seen_sid = -1, seen_ev = -1;
    bit          seen_new;
    logic [15:0] seen_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // flow table at the level of the rules: hit, else lowest free, else round-robin victim
    task automatic model_lookup(input logic [31:0] k, output int sid, output bit nw);
        sid = -1;
        for (int i = 63; i >= 0; i--) if (m_val[i] && m_key[i] == k) sid = i;
        nw = (sid < 0);
        if (nw) begin
            for (int i = 63; i >= 0; i--) if (!m_val[i]) sid = i;
            if (sid < 0) begin
                sid  = m_rr;
                m_rr = (m_rr + 1) % 64;
                if (m_evict < 65535) m_evict++;
            end
            m_key[sid] = k;
            m_val[sid] = 1'b1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_char_in"}, 32'(char_in), 0);
        chk({tag, "_char_in_vld"}, 32'(char_in_vld), 0);
        chk({tag, "_load_state"}, 32'(load_state), 0);
        chk({tag, "_stream_id"}, 32'(stream_id), 0);
        chk({tag, "_new_stream_id"}, 32'(new_stream_id), 0);
        chk({tag, "_eop"}, 32'(eop), 0);
        chk({tag, "_enable"}, 32'(enable), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_evict_cnt"}, 32'(evict_cnt), 0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; cfg_we = 1'b0;
        rst_n = 1'b0;
        ld_q.delete();
        by_q.delete();
        for (int i = 0; i < 64; i++) m_val[i] = 1'b0;
        m_rr = 0; m_evict = 0; m_drop = 0;
        @(posedge clk); #1;
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input int a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = 6'(a); cfg_wdata = d;
        @(posedge clk); #1;
        m_en[a] = d;
        cfg_we = 1'b0;
    endtask

    task automatic drop_byte(input logic [7:0] d);
        in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'($urandom); in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (m_drop < 65535) m_drop++;
    endtask

    // sends pkt[] under key; bub = bubble percent; cmode 0 none / 1 random addr / 2 current sid;
    // abort > 0 resets the DUT once that many bytes are accepted
    task automatic send_pkt(input logic [31:0] key, input int bub, input int cmode, input int abort);
        int  sid, idx, cyc, n;
        bit  nw, acc;
        n = pkt.size();
        model_lookup(key, sid, nw);
        ld_q.push_back('{sid: sid, nw: nw, en: m_en[sid], ev: m_evict});
        for (int i = 0; i < n; i++) by_q.push_back('{d: pkt[i], last: (i == n - 1)});
        in_flow_key = key;
        idx = 0;
        cyc = 0;
        while (idx < n) begin
            in_valid = (cyc == 0) ? 1'b1 : 1'($urandom_range(99) >= bub);
            in_data  = in_valid ? pkt[idx] : 8'($urandom);
            in_sop   = (idx == 0) || ($urandom_range(3) == 0);
            in_eop   = (idx == n - 1);
            if (cyc >= 1 && cmode != 0 && $urandom_range(3) == 0) begin
                cfg_we    = 1'b1;
                cfg_addr  = (cmode == 2) ? 6'(sid) : 6'($urandom);
                cfg_wdata = 16'($urandom);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (cfg_we) begin
                m_en[cfg_addr] = cfg_wdata;
                cfg_we = 1'b0;
            end
            if (acc) idx++;
            cyc++;
            if (abort != 0 && idx == abort) begin
                do_reset();
                return;
            end
            if (cyc > 500) begin
                chk("pkt_timeout", 32'(idx), 32'(n));
                break;
            end
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        @(posedge clk); #1;
    endtask

    // single compare process: every load, char and eop is checked against the model queues
    initial begin
        ld_t cur;
        by_t b;
        bit  prev_last;
        cur = '{sid: 0, nw: 1'b0, en: 16'h0, ev: 0};
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (!rst_n) begin
                prev_last = 1'b0;
                continue;
            end
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            if (load_state) begin
                chk("load_expected", 32'(ld_q.size() != 0), 1);
                if (ld_q.size() != 0) begin
                    cur = ld_q.pop_front();
                    chk("load_sid", 32'(stream_id), 32'(cur.sid));
                    chk("load_new", 32'(new_stream_id), 32'(cur.nw));
                    chk("load_enable", 32'(enable), 32'(cur.en));
                    chk("load_evict_cnt", 32'(evict_cnt), 32'(cur.ev));
                    seen_sid = int'(stream_id); seen_new = new_stream_id;
                    seen_en = enable; seen_ev = int'(evict_cnt);
                    load_cyc = cyc_n; first_gap = -1; pkt_chars = 0;
                end
            end
            if (prev_last || eop) chk("eop_after_last", 32'(eop), 32'(prev_last));
            prev_last = 1'b0;
            if (char_in_vld) begin
                chk("char_expected", 32'(by_q.size() != 0), 1);
                if (by_q.size() != 0) begin
                    b = by_q.pop_front();
                    chk("char_in", 32'(char_in), 32'(b.d));
                    chk("held_sid", 32'(stream_id), 32'(cur.sid));
                    chk("held_enable", 32'(enable), 32'(cur.en));
                    chk("held_new", 32'(new_stream_id), 32'(cur.nw));
                    prev_last = b.last;
                    if (first_gap < 0) first_gap = cyc_n - load_cyc;
                    pkt_chars++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'h0;
        in_flow_key = 32'h0; cfg_we = 1'b0; cfg_addr = 6'h0; cfg_wdata = 16'h0;
        for (int i = 0; i < 64; i++) m_val[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("por");
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) cfg_write(i, 16'($urandom));

        pkt = '{8'h41, 8'h42, 8'h43, 8'h44};
        send_pkt(32'hA5A5_0001, 0, 0, 0);
        chk("p1_sid_lit", 32'(seen_sid), 0);
        chk("p1_new_lit", 32'(seen_new), 1);
        chk("p1_latency_lit", 32'(first_gap), 2);
        chk("p1_chars_lit", 32'(pkt_chars), 4);

        cfg_write(0, 16'h0005);
        pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_pkt(32'hA5A5_0001, 20, 2, 0);
        chk("p2_sid_lit", 32'(seen_sid), 0);
        chk("p2_new_lit", 32'(seen_new), 0);
        chk("p2_enable_lit", 32'(seen_en), 32'h0005);

        for (int k = 1; k < 64; k++) begin
            pkt.delete();
            for (int i = 0; i < 1 + $urandom_range(2); i++) pkt.push_back(8'($urandom));
            send_pkt(32'h1000_0000 + 32'(k), 30, 1, 0);
        end
        chk("fill_last_sid_lit", 32'(seen_sid), 63);
        chk("fill_evict_lit", 32'(evict_cnt), 0);

        pkt = '{8'h55, 8'h66};
        send_pkt(32'h2000_0000, 0, 0, 0);
        chk("ev1_sid_lit", 32'(seen_sid), 0);
        chk("ev1_new_lit", 32'(seen_new), 1);
        chk("ev1_cnt_lit", 32'(seen_ev), 1);
        send_pkt(32'h2000_0001, 0, 0, 0);
        chk("ev2_sid_lit", 32'(seen_sid), 1);
        chk("ev2_cnt_lit", 32'(seen_ev), 2);

        drop_byte(8'h10);
        drop_byte(8'h11);
        chk("drop_lit", 32'(drop_cnt), 2);

        pkt = '{8'h7F};
        send_pkt(32'h2000_0000, 50, 0, 0);
        chk("single_chars_lit", 32'(pkt_chars), 1);
        chk("single_sid_lit", 32'(seen_sid), 0);
        chk("single_new_lit", 32'(seen_new), 0);

        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(3) == 0)
                for (int d = 0; d <= int'($urandom_range(1)); d++) drop_byte(8'($urandom));
            if ($urandom_range(3) == 0) cfg_write(int'($urandom_range(63)), 16'($urandom));
            pkt.delete();
            for (int i = 0; i < 1 + $urandom_range(5); i++) pkt.push_back(8'($urandom));
            send_pkt(32'h3000_0000 + 32'($urandom_range(79)), 25, 1, 0);
        end

        pkt = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        send_pkt(32'h2000_0001, 0, 0, 2);
        pkt = '{8'hB0, 8'hB1};
        send_pkt(32'h2000_0001, 0, 0, 0);
        chk("post_rst_sid_lit", 32'(seen_sid), 0);
        chk("post_rst_new_lit", 32'(seen_new), 1);
        chk("post_rst_evict_lit", 32'(seen_ev), 0);

        for (int p = 0; p < 10; p++) begin
            pkt.delete();
            for (int i = 0; i < 1 + $urandom_range(4); i++) pkt.push_back(8'($urandom));
            send_pkt(32'h4000_0000 + 32'($urandom_range(7)), 25, 1, 0);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("ld_q_drained", 32'(ld_q.size()), 0);
        chk("by_q_drained", 32'(by_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dpi_stream_dispatcher.md
Name: dpi_stream_dispatcher

Overview:
- Front end that drives the per-stream regex matcher bank.
- Accepts packet bytes on a valid/ready byte stream and maps each packet's flow key to a 6-bit stream_id through a 64-entry flow table.
- Sequences load_state, char stream and eop onto the matcher-bank bus, and supplies the per-stream regex enable vector.

Parameters:
FLOW_KEY_W, 32, width of flow key carried on the SOP beat
NUM_REGEX, 16, number of matcher instances, i.e. width of the enable vector
NUM_STREAMS, 64, flow table depth; fixed at 64 because stream_id is 6 bits

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
in_valid  in  1  input byte valid
in_ready  out  1  input byte accepted when in_valid & in_ready
in_data  in  8  packet byte
in_sop  in  1  first byte of packet
in_eop  in  1  last byte of packet
in_flow_key  in  FLOW_KEY_W  flow key; sampled only on the SOP beat
cfg_we  in  1  enable-table write strobe
cfg_addr  in  6  enable-table index (stream_id)
cfg_wdata  in  NUM_REGEX  enable mask to write
char_in  out  8  byte to matchers
char_in_vld  out  1  char_in valid
load_state  out  1  one-cycle pulse; matchers restore or clear state
stream_id  out  6  current stream; stable from LOAD through EOP
new_stream_id  out  1  1 = freshly allocated entry, so matchers zero their state; stable with stream_id
eop  out  1  one-cycle end-of-packet pulse to matchers
enable  out  NUM_REGEX  per-regex enable for current stream; stable from LOAD through EOP
busy  out  1  state != IDLE
evict_cnt  out  16  count of flow-table evictions, saturating
drop_cnt  out  16  count of non-SOP bytes discarded in IDLE, saturating

Behaviour:
- Reset: every output 0; all table valid bits cleared; rr_ptr=0; counters 0; FSM goes to IDLE. Reset mid-packet aborts immediately and emits no eop. Enable-table contents are not reset (RAM).
- FSM states: IDLE, LOOKUP, LOAD, GAP, STREAM, EOP.
- IDLE:
  - in_ready = ~in_sop.
  - Beat with in_valid & ~in_sop: consumed and discarded, drop_cnt++.
  - in_valid & in_sop: beat is not consumed; in_flow_key is latched; go to LOOKUP.
- LOOKUP (1 cycle): compare the latched key in parallel against all valid entries.
  - Hit: sid = hit index, new = 0.
  - Miss, any invalid entry: sid = lowest invalid index, new = 1; write key and set valid.
  - Miss, table full: sid = rr_ptr, new = 1; overwrite key; rr_ptr++ (wraps 63→0); evict_cnt++.
  - Register stream_id, new_stream_id, and enable = enable_table[sid].
- LOAD (1 cycle): load_state = 1. Go to GAP.
- GAP (1 cycle): all strobes 0. Matchers see state_in_vld this cycle.
- STREAM:
  - in_ready = 1; char_in = in_data; char_in_vld = in_valid. Both are combinational pass-through; zero latency and no bubbles.
  - in_sop on a STREAM beat is ignored; the beat is treated as data.
  - Accepted beat with in_eop goes to EOP. A single-byte packet (sop & eop) is legal.
- EOP (1 cycle): eop = 1, char_in_vld = 0, in_ready = 0. Go to IDLE.
- Latency: the SOP byte reaches char_in no earlier than 3 cycles after it first appears in IDLE. eop is asserted exactly 1 cycle after the last char_in_vld.
- enable and stream_id are held constant until the next LOOKUP. cfg writes take effect from the next packet's LOOKUP. A write to the current stream's entry does not alter the held enable.
- Counters saturate at 16'hFFFF.

Optional Feature:
- Macro: DPI_FLOW_INVAL_EN.
- When defined: adds inputs inval_req (1) and inval_id (6).
  - Asserting inval_req clears valid[inval_id] at the next edge.
  - If this coincides with LOOKUP writing the same index, the LOOKUP write wins.
  - Invalidating the in-flight stream does not disturb the current packet.
- When undefined: ports absent; entries leave the table only by round-robin eviction.

Decomposition:
- Shared package dpi_pkg holds:
  - STREAM_ID_W = 6
  - NUM_STREAMS = 64
  - FSM state enum
  - typedef flow_entry_t {valid, key}
- One natural sub-module: dpi_flow_table, holding key/valid storage, the parallel compare, lowest-free priority encoder, rr_ptr, eviction, and the optional invalidation port. The FSM, handshake and counters stay in the top.

Test Plan:
- Fresh reset; packet key=0xA5A5_0001, 4 bytes 0x41..0x44 → load_state with stream_id=0, new_stream_id=1; char_in 41,42,43,44 starting cycle LOAD+2; eop 1 cycle after 0x44.
- Repeat key 0xA5A5_0001 → stream_id=0, new_stream_id=0; cfg_addr=0 written 16'h0005 beforehand → enable=16'h0005 held through eop.
- 64 distinct keys, then a 65th key → ids 0..63 allocated in order; 65th gets stream_id=0, new=1, evict_cnt=1; 66th new key gets stream_id=1, evict_cnt=2.
- Non-SOP bytes 0x10, 0x11 while IDLE → drop_cnt=2, no char_in_vld, no load_state.
- Single-byte packet (sop & eop, data 0x7F) with in_valid toggling during STREAM → exactly one char_in_vld; eop next cycle; bubbles pass through unchanged.
- rst_n low during STREAM after 2 bytes → all outputs 0 next cycle, no eop; next packet with the same key → new_stream_id=1 (table cleared).
